// File: rtl/pnr_gpio_hist_receiver.sv
// Far-end receiver for the one-hot PNR photon bus: synchronise, detect/decode bursts, build a histogram.
// Build option PNR_HIST_SATURATE_EN: bins and shot counter saturate instead of wrapping.

module pnr_hist_bin #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
`ifdef PNR_HIST_SATURATE_EN
    else if (inc && (cnt != '1)) cnt <= cnt + W'(1);
`else
    else if (inc) cnt <= cnt + W'(1);
`endif
  end

endmodule

module pnr_gpio_hist_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 32,
  parameter int ERR_W       = 16
) (
  input  logic             ADC_CLK,
  input  logic             rst_i,
  input  logic [7:0]       extension_GPIO_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] shot_target_i,
  input  logic [2:0]       rd_addr_i,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [2:0]       photon_num_o,
  output logic             photon_valid_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] shot_cnt_o,
  output logic [ERR_W-1:0] err_cnt_o
);

  typedef enum logic [1:0] {IDLE, CLEAR, ACQ, DONE} state_t;

  logic [SYNC_STAGES-1:0][7:0] sync_q;
  logic [7:0]                  s;
  logic                        prev_any;
  logic                        evt, onehot, valid_evt, err_evt;
  logic [2:0]                  idx;
  state_t                      state;
  logic [CNT_W-1:0]            tgt_q;
  logic                        tgt_met, cnt_en, clr;
  logic [7:0][CNT_W-1:0]       bin_cnt;

  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      prev_any <= 1'b0;
    end else begin
      sync_q[0] <= extension_GPIO_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_any <= |s;
    end
  end

  assign s         = sync_q[SYNC_STAGES-1];
  assign evt       = (|s) && !prev_any;
  assign onehot    = ((s & (s - 8'd1)) == 8'h00);
  assign valid_evt = evt && onehot;
  assign err_evt   = evt && !onehot;

  always_comb begin
    idx = 3'd0;
    for (int k = 0; k < 8; k++) if (s[k]) idx = 3'(k);
  end

  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      photon_valid_o <= 1'b0;
      photon_num_o   <= 3'd0;
    end else begin
      photon_valid_o <= valid_evt;
      if (valid_evt) photon_num_o <= idx;
    end
  end

  // Once a nonzero target is met, further events are ignored until the FSM leaves ACQ.
  assign tgt_met = (tgt_q != '0) && (shot_cnt_o >= tgt_q);
  assign cnt_en  = (state == ACQ) && !tgt_met && valid_evt;
  assign clr     = (state == CLEAR);

  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      tgt_q  <= '0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          state  <= CLEAR;
          busy_o <= 1'b1;
        end
        CLEAR: begin
          state <= ACQ;
          tgt_q <= shot_target_i;
        end
        ACQ: if (start_i) begin
          state <= CLEAR;
        end else if (stop_i || tgt_met) begin
          state  <= DONE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        DONE: if (start_i) begin
          state  <= CLEAR;
          busy_o <= 1'b1;
          done_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) begin
      shot_cnt_o <= '0;
      err_cnt_o  <= '0;
    end else if (clr) begin
      shot_cnt_o <= '0;
      err_cnt_o  <= '0;
    end else begin
`ifdef PNR_HIST_SATURATE_EN
      if (cnt_en && (shot_cnt_o != '1)) shot_cnt_o <= shot_cnt_o + CNT_W'(1);
`else
      if (cnt_en) shot_cnt_o <= shot_cnt_o + CNT_W'(1);
`endif
      if ((state == ACQ) && err_evt && (err_cnt_o != '1)) err_cnt_o <= err_cnt_o + ERR_W'(1);
    end
  end

  for (genvar b = 0; b < 8; b++) begin : g_bin
    pnr_hist_bin #(.W(CNT_W)) u_bin (
      .clk (ADC_CLK),
      .rst (rst_i),
      .clr (clr),
      .inc (cnt_en && (idx == 3'(b))),
      .cnt (bin_cnt[b])
    );
  end

  always_ff @(posedge ADC_CLK or posedge rst_i) begin
    if (rst_i) rd_data_o <= '0;
    else       rd_data_o <= bin_cnt[rd_addr_i];
  end

endmodule

// File: tb/tb_pnr_gpio_hist_receiver.sv
// Directed bench for pnr_gpio_hist_receiver: expected photon numbers go through a scoreboard queue.
module tb_pnr_gpio_hist_receiver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  gpio = 8'h00;
  logic        start = 1'b0, stop = 1'b0;
  logic [31:0] target = 32'd0;
  logic [2:0]  rd_addr = 3'd0;
  logic [31:0] rd_data, shot_cnt;
  logic [2:0]  pnum;
  logic        pvalid, busy, done;
  logic [15:0] err_cnt;

  logic [7:0]  gpio6 = 8'h00;
  logic        start6 = 1'b0;
  logic [2:0]  rd_addr6 = 3'd0;
  logic [3:0]  rd_data6, shot_cnt6;
  logic [2:0]  pnum6;
  logic        pvalid6, busy6, done6;
  logic [15:0] err_cnt6;

  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  pnr_gpio_hist_receiver u_dut (
    .ADC_CLK(clk), .rst_i(rst), .extension_GPIO_i(gpio), .start_i(start), .stop_i(stop),
    .shot_target_i(target), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .photon_num_o(pnum),
    .photon_valid_o(pvalid), .busy_o(busy), .done_o(done), .shot_cnt_o(shot_cnt), .err_cnt_o(err_cnt)
  );

  pnr_gpio_hist_receiver #(.CNT_W(4)) u_dut6 (
    .ADC_CLK(clk), .rst_i(rst), .extension_GPIO_i(gpio6), .start_i(start6), .stop_i(1'b0),
    .shot_target_i(4'd0), .rd_addr_i(rd_addr6), .rd_data_o(rd_data6), .photon_num_o(pnum6),
    .photon_valid_o(pvalid6), .busy_o(busy6), .done_o(done6), .shot_cnt_o(shot_cnt6), .err_cnt_o(err_cnt6)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_bin(input string name, input logic [2:0] a, input logic [31:0] exp);
    rd_addr = a;
    tick(1);
    chk(name, rd_data, exp);
  endtask

  // One burst: code held 'hold' cycles, then the bus idles long enough to re-arm detection.
  task automatic ev(input logic [7:0] code, input int hold);
    if ($countones(code) == 1)
      for (int k = 0; k < 8; k++) if (code[k]) exp_q.push_back(3'(k));
    gpio = code;
    tick(hold);
    gpio = 8'h00;
    tick(4);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
  endtask

  always @(negedge clk) begin
    if (pvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: got photon %0d expected no event", pnum);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (pnum !== e) begin
          errors++;
          $display("FAIL photon_num: got %0d expected %0d", pnum, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_shot", shot_cnt, 0);
    chk("rst_rd", rd_data, 0);
    rst = 1'b0;
    tick(2);

    // T2: single event, latency and result
    target = 0;
    pulse_start();
    chk("t2_busy", busy, 1);
    exp_q.push_back(3'd2);
    gpio = 8'h04;
    tick(2);
    chk("t2_early", pvalid, 0);
    tick(1);
    chk("t2_latency", pvalid, 1);
    gpio = 8'h00;
    tick(4);
    chk("t2_num", pnum, 2);
    chk("t2_shot", shot_cnt, 1);
    chk_bin("t2_bin2", 3'd2, 1);

    // T3: histogram with target 5
    target = 5;
    pulse_start();
    ev(8'h01, 1); ev(8'h02, 1); ev(8'h02, 1); ev(8'h80, 1); ev(8'h10, 1);
    chk("t3_done", done, 1);
    chk("t3_busy", busy, 0);
    ev(8'h04, 1);
    chk("t3_shot", shot_cnt, 5);
    chk_bin("t3_bin0", 3'd0, 1);
    chk_bin("t3_bin1", 3'd1, 2);
    chk_bin("t3_bin7", 3'd7, 1);
    chk_bin("t3_bin4", 3'd4, 1);
    chk_bin("t3_bin2", 3'd2, 0);
    chk("t3_num", pnum, 2);

    // T4: multi-hot error event
    target = 0;
    pulse_start();
    ev(8'h06, 2);
    chk("t4_err", err_cnt, 1);
    chk("t4_shot", shot_cnt, 0);
    chk_bin("t4_bin1", 3'd1, 0);
    chk_bin("t4_bin2", 3'd2, 0);
    chk("t4_num_hold", pnum, 2);

    // T5: event coincident with stop
    exp_q.push_back(3'd0);
    gpio = 8'h01;
    tick(2);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    gpio = 8'h00;
    chk("t5_done", done, 1);
    chk("t5_shot", shot_cnt, 1);
    chk_bin("t5_bin0", 3'd0, 1);
    tick(3);

    // T5: start+stop together while acquiring
    pulse_start();
    ev(8'h03, 1);
    ev(8'h20, 1);
    chk("t5_err_pre", err_cnt, 1);
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    chk("t5_clear_busy", busy, 1);
    chk("t5_clear_done", done, 0);
    tick(1);
    chk("t5_acq_busy", busy, 1);
    chk("t5_err_clr", err_cnt, 0);
    chk("t5_shot_clr", shot_cnt, 0);
    chk_bin("t5_bin5_clr", 3'd5, 0);

    // T1: reset mid-acquisition
    ev(8'h08, 1);
    chk("t1_shot_pre", shot_cnt, 1);
    rd_addr = 3'd3;
    tick(1);
    chk("t1_rd_pre", rd_data, 1);
    #2 rst = 1'b1;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_shot", shot_cnt, 0);
    chk("t1_err", err_cnt, 0);
    chk("t1_num", pnum, 0);
    chk("t1_rd", rd_data, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    chk_bin("t1_bin3", 3'd3, 0);
    ev(8'h01, 1);
    chk("t1_idle_shot", shot_cnt, 0);
    chk("t1_idle_busy", busy, 0);

    // T6: 4-bit counters, 17 events on bin 0
    start6 = 1'b1;
    tick(1);
    start6 = 1'b0;
    tick(1);
    for (int i = 0; i < 17; i++) begin
      gpio6 = 8'h01;
      tick(1);
      gpio6 = 8'h00;
      tick(4);
    end
    rd_addr6 = 3'd0;
    tick(1);
`ifdef PNR_HIST_SATURATE_EN
    chk("t6_bin0", rd_data6, 15);
    chk("t6_shot", shot_cnt6, 15);
`else
    chk("t6_bin0", rd_data6, 1);
    chk("t6_shot", shot_cnt6, 1);
`endif
    chk("t6_busy", busy6, 1);

    tick(4);
    chk("pending_events", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
